// File: rtl/ascii_dec2bin.sv
// rtl/ascii_dec2bin.sv - ASCII decimal token parser producing one binary value per token
// Digits accumulate as acc*10+d; any non-digit byte closes a non-empty token.
module ascii_dec2bin #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_VALUE,
    output logic [4:0]       OUT_DIGITS,
    output logic             OUT_OVERFLOW,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic [4:0]       out_digits_q, out_digits_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_fire;
    logic             is_digit;
    logic [3:0]       digit;
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] prod;
    logic             prod_ovf;
    logic [4:0]       cnt_inc;

    assign OUT_VALID    = (state_q == S_DONE);
    assign IN_READY     = !OUT_VALID;
    assign OUT_VALUE    = out_value_q;
    assign OUT_DIGITS   = out_digits_q;
    assign OUT_OVERFLOW = out_ovf_q;

    assign in_fire  = IN_VALID && IN_READY;
    assign is_digit = (IN_DATA >= 8'h30) && (IN_DATA <= 8'h39);
    assign digit    = IN_DATA[3:0];

    // acc*10 as (acc<<3)+(acc<<1); four guard bits catch any carry past WIDTH.
    assign acc_ext  = {4'b0000, acc_q};
    assign prod     = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
    assign prod_ovf = (|prod[WIDTH+3:WIDTH]) || ovf_q;
    assign cnt_inc  = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        out_value_d  = out_value_q;
        out_digits_d = out_digits_q;
        out_ovf_d    = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire && is_digit) begin
                    acc_d   = {{(WIDTH-4){1'b0}}, digit};
                    cnt_d   = 5'd1;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire) begin
                    if (is_digit) begin
                        cnt_d = cnt_inc;
                        if (prod_ovf) begin
                            ovf_d = 1'b1;
                            acc_d = {WIDTH{1'b1}};
                        end else begin
                            acc_d = prod[WIDTH-1:0];
                        end
                    end else begin
                        out_value_d  = acc_q;
                        out_digits_d = cnt_q;
                        out_ovf_d    = ovf_q;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result registers keep their contents; only the working state clears.
                if (OUT_READY) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            out_value_q  <= '0;
            out_digits_q <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            out_value_q  <= out_value_d;
            out_digits_q <= out_digits_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_ascii_dec2bin.sv
// tb/tb_ascii_dec2bin.sv - scoreboard bench for ascii_dec2bin with a numeric token model
// Expected results are queued as bytes are accepted; a monitor checks each result as it appears.
module tb_ascii_dec2bin;

    localparam int WIDTH = 32;
    localparam longint unsigned VMAX = (64'd1 << WIDTH) - 64'd1;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic [7:0]       IN_DATA = 8'h00;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT_VALUE;
    logic [4:0]       OUT_DIGITS;
    logic             OUT_OVERFLOW;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b1;

    ascii_dec2bin #(.WIDTH(WIDTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_VALUE(OUT_VALUE), .OUT_DIGITS(OUT_DIGITS), .OUT_OVERFLOW(OUT_OVERFLOW),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        longint unsigned value;
        int              digits;
        bit              ovf;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_edge = -1;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

    // Token model: plain decimal arithmetic; once past 2^WIDTH-1 the value is irrelevant.
    bit              m_in_tok = 0;
    longint unsigned m_val = 0;
    bit              m_ovf = 0;
    int              m_nd = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(posedge CLOCK) begin
        #2;
        case (rdy_mode)
            0:       OUT_READY = ($urandom_range(0, 3) != 0);
            2:       OUT_READY = 1'b0;
            default: OUT_READY = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_feed(input logic [7:0] b, input int c);
        exp_t e;
        if (b >= "0" && b <= "9") begin
            if (!m_in_tok) begin
                m_in_tok = 1; m_val = 0; m_ovf = 0; m_nd = 0;
            end
            m_nd++;
            if (!m_ovf) begin
                m_val = m_val * 10 + longint'(b - "0");
                if (m_val > VMAX) m_ovf = 1;
            end
        end else if (m_in_tok) begin
            e.value  = m_ovf ? VMAX : m_val;
            e.digits = (m_nd > 31) ? 31 : m_nd;
            e.ovf    = m_ovf;
            e.cyc    = c;
            exp_q.push_back(e);
            m_in_tok = 0;
        end
    endtask

    int last_acc = 0;

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge CLOCK);
        IN_DATA = b;
        IN_VALID = 1'b1;
        while (!IN_READY && t < 300) begin
            @(negedge CLOCK);
            t++;
        end
        if (!IN_READY) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            IN_VALID = 1'b0;
            return;
        end
        @(posedge CLOCK);
        #1;
        last_acc = cyc;
        model_feed(b, cyc);
        IN_VALID = 1'b0;
        IN_DATA = $urandom_range(0, 255);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    function automatic logic [7:0] rand_delim();
        logic [7:0] b;
        do b = $urandom_range(0, 255); while (b >= "0" && b <= "9");
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge CLOCK);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        idle(2);
    endtask

    // Monitor: new results are checked on their first valid cycle, held ones for stability.
    logic             prev_valid = 0, prev_ready = 0;
    logic [WIDTH-1:0] hold_value;
    logic [4:0]       hold_digits;
    logic             hold_ovf;

    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (OUT_VALID) begin
                chk("in_ready_low_when_valid", IN_READY, 0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        chk("value", OUT_VALUE, exp_q[0].value);
                        chk("digits", OUT_DIGITS, exp_q[0].digits);
                        chk("overflow", OUT_OVERFLOW, exp_q[0].ovf);
                        chk("latency", cyc, exp_q[0].cyc);
                    end
                end else if (!prev_ready) begin
                    chk("hold_value", OUT_VALUE, hold_value);
                    chk("hold_digits", OUT_DIGITS, hold_digits);
                    chk("hold_ovf", OUT_OVERFLOW, hold_ovf);
                end
                if (OUT_READY) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    hs_edge = cyc + 1;
                end
            end
        end
        prev_valid  = OUT_VALID;
        prev_ready  = OUT_READY;
        hold_value  = OUT_VALUE;
        hold_digits = OUT_DIGITS;
        hold_ovf    = OUT_OVERFLOW;
    end

    initial begin
        #3;
        chk("reset_value", OUT_VALUE, 0);
        chk("reset_digits", OUT_DIGITS, 0);
        chk("reset_ovf", OUT_OVERFLOW, 0);
        chk("reset_valid", OUT_VALID, 0);
        #20;
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("ready_after_reset", IN_READY, 1);

        rdy_mode = 1;
        send_str("255,");
        drain();

        for (int i = 0; i <= 260; i++) begin
            send_str($sformatf("%0d", i));
            send(rand_delim());
        end
        drain();

        send_str("4294967295\n");
        send_str("4294967296\n");
        send_str("12 ");
        drain();

        send_str(",,  7;");
        send_str("00042x");
        for (int i = 0; i < 40; i++) send("0");
        send("\n");
        drain();

        // Stall the consumer with the next token already presented.
        rdy_mode = 2;
        send_str("9\n");
        fork
            send("8");
            begin
                repeat (10) begin
                    @(negedge CLOCK);
                    chk("stall_in_ready", IN_READY, 0);
                    chk("stall_valid", OUT_VALID, 1);
                end
                rdy_mode = 1;
            end
        join
        chk("accept_after_handshake", last_acc, hs_edge + 1);
        send("\n");
        drain();

        // Asynchronous reset between edges discards the partial token.
        send_str("123");
        @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        #1;
        chk("async_rst_value", OUT_VALUE, 0);
        chk("async_rst_digits", OUT_DIGITS, 0);
        chk("async_rst_valid", OUT_VALID, 0);
        m_in_tok = 0;
        @(negedge CLOCK);
        RESET = 1'b0;
        send_str("5;");
        drain();

        rdy_mode = 0;
        for (int k = 0; k < 300; k++) begin
            int nd;
            nd = $urandom_range(1, 14);
            if ($urandom_range(0, 2) == 0) send(rand_delim());
            for (int j = 0; j < nd; j++) begin
                send(8'h30 + 8'($urandom_range(0, 9)));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
            send(rand_delim());
        end
        rdy_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
